imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory loader for the pipelined MIPS core. It accepts a byte stream under a valid/ready handshake and packs it big-endian into 32-bit instruction words, so byte 0 carries inst[31:24] (opcode first). It writes the words to consecutive instruction-memory addresses and holds the CPU pipeline until the image is complete. It is the writer side of the instruction path that the fetch stage and instruction decoder read.

## Interface
- ADDR_W, 8, instruction-memory word-address width; maximum image size is 2^ADDR_W words.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte; a byte transfers when in_valid & in_ready.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  packed instruction word.
- cpu_hold  out  1  holds the core (stall and flush fetch) while high.
- done  out  1  image loaded successfully; level signal.
- error  out  1  load aborted; level signal.

## Operation
- States and transitions:
  - IDLE: start moves to LEN_HI.
  - LEN_HI: the accepted byte is len[15:8]; move to LEN_LO.
  - LEN_LO: the accepted byte is len[7:0].
    - len == 0 moves to DONE, or to CSUM when the checksum feature is built in.
    - len > 2^ADDR_W moves to ERR.
    - Otherwise move to DATA.
  - DATA: accept bytes until len words have been received, then move to DONE or CSUM.
  - CSUM: accept one byte, then move to DONE or ERR.
  - DONE and ERR: start moves to LEN_HI.
- in_ready = 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 otherwise.
- Byte packing:
  - A 2-bit byte counter selects the lane; lane 0 goes to [31:24] and lane 3 to [7:0].
  - Accepting lane 3 completes a word.
  - in_valid low inserts wait cycles and leaves the counter unchanged.
- Word write:
  - imem_we pulses for exactly one cycle per completed word.
  - imem_addr starts at 0 and increments by 1 after each write.
  - A full 2^ADDR_W-word image ends at address 2^ADDR_W-1; the address counter never wraps into a write.
- cpu_hold:
  - Set on reset and on accepted start.
  - Cleared only on entry to DONE.
  - Stays 1 in ERR.
- done and error:
  - Accepted start clears both.
  - Entry to DONE sets done; entry to ERR sets error.
  - They are never both 1.
- start while in LEN_HI, LEN_LO, DATA or CSUM is ignored.
- Reset mid-load returns every output to its reset value. Words already written stay in memory.
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, error=0, state IDLE.

## Timing
- start high in cycle t gives in_ready=1 at t+1.
- Word write latency: lane-3 byte accepted in cycle t gives imem_we=1 with the final addr/wdata at t+1. imem_wdata and imem_addr are registered and hold until the next write.
- Last data byte accepted at t, without checksum:
  - imem_we, done=1 and cpu_hold=0 all at t+1.
  - in_ready=0 from t+1.
- With checksum: the CSUM byte accepted at t gives done or error at t+1.
- len == 0 with LEN_LO accepted at t gives done=1 at t+1 and no imem_we, when the checksum feature is not built in.
- A back-to-back stream sustains 1 byte per cycle with no bubbles.

## Configuration
- LOADER_CSUM_EN defined:
  - A running XOR of all DATA bytes is kept; it is cleared on start.
  - One extra CSUM byte follows the data.
  - Match moves to DONE; mismatch moves to ERR with error=1 and cpu_hold=1.
- LOADER_CSUM_EN undefined:
  - No CSUM state exists and no trailing byte is consumed.
  - DONE follows the last data byte directly.

## Test plan
- Load 2 words:
  - Stimulus: start, then stream 00 02 | 20 08 00 05 | 8C 09 00 04 at 1 byte/cycle.
  - Required: imem_we at addr 0 with 0x20080005, then at addr 1 with 0x8C090004.
  - Required: done=1 and cpu_hold=0 in the same cycle as the second write (checksum feature not built in).
- Throttled stream: same image with in_valid toggled 1/0 every cycle -> identical writes and data; each write lags its lane-3 byte by one cycle.
- Oversize length (ADDR_W=8): stream 01 01 -> error=1, cpu_hold=1, no imem_we, in_ready=0.
- Checksum (LOADER_CSUM_EN defined):
  - 1-word image 00 01 12 34 56 78 followed by CSUM 08 -> done=1.
  - Repeat with CSUM 09 -> error=1 and done=0.
- Reset mid-load: assert rst_n=0 after 6 data bytes -> all outputs at reset values immediately.
  - A new start and full image then loads from addr 0 with done=1.
- Boundaries:
  - len=0 -> done with no writes.
  - len=256 -> last write at addr 255, done=1.
  - start pulsed during DATA -> ignored, with no restart and no change to imem_addr.

Source files
------------

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction-memory loader for the pipelined MIPS core.
//
// The loader takes a byte stream under a valid/ready handshake. The first two
// bytes give the image length in words, high byte first. The data bytes that
// follow are packed big-endian into 32-bit instruction words: the first byte
// of each word lands in inst[31:24], so the opcode arrives first. Each word is
// written to consecutive instruction-memory word addresses, starting at 0.
// The core is held (cpu_hold) until the whole image has been written.
//
// Optional feature (compile-time macro LOADER_CSUM_EN):
//   When the macro is defined, one checksum byte follows the data. It must
//   equal the XOR of all data bytes. A match completes the load; a mismatch
//   aborts it with error=1. When the macro is undefined, there is no checksum
//   state and the load completes on the last data byte.
//
// Parameters:
//   ADDR_W      instruction-memory word-address width (image <= 2^ADDR_W words)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       one-cycle load request, honoured in IDLE / DONE / ERR only
//   in_valid    stream byte valid
//   in_data     stream byte
//   in_ready    loader accepts a byte this cycle
//   imem_we     one-cycle write strobe per completed word
//   imem_addr   word address of the write (held until the next write)
//   imem_wdata  packed instruction word (held until the next write)
//   cpu_hold    stall/flush the core while high
//   done        image loaded (level)
//   error       load aborted (level)
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
`ifdef LOADER_CSUM_EN
    ST_CSUM   = 3'd4,
`endif
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  // Largest legal image in words. The 17-bit width keeps 2^16 representable.
  localparam logic [16:0] MAX_WORDS_C = 17'd1 << ADDR_W;

`ifdef LOADER_CSUM_EN
  // Running checksum step: XOR of every data byte seen so far.
  function automatic logic [7:0] csum_update(input logic [7:0] acc,
                                             input logic [7:0] data_byte);
    return acc ^ data_byte;
  endfunction
`endif

  state_t              state_r;
  state_t              state_nxt_s;
  logic                in_ready_r;
  logic                in_ready_nxt_s;
  logic                imem_we_r;
  logic [ADDR_W-1:0]   imem_addr_r;
  logic [ADDR_W-1:0]   next_addr_r;
  logic [31:0]         imem_wdata_r;
  logic                cpu_hold_r;
  logic                done_r;
  logic                error_r;

  logic [7:0]          len_hi_r;
  logic [16:0]         words_left_r;
  logic [1:0]          lane_r;
  logic [23:0]         buf_r;
`ifdef LOADER_CSUM_EN
  logic [7:0]          csum_r;
`endif

  logic                accept_s;
  logic                start_acc_s;
  logic                data_acc_s;
  logic                word_done_s;
  logic                enter_done_s;
  logic                enter_err_s;
  logic [15:0]         len_s;

  assign in_ready   = in_ready_r;
  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign cpu_hold   = cpu_hold_r;
  assign done       = done_r;
  assign error      = error_r;

  // Next-state logic and the one-cycle event flags consumed by the registers.
  always_comb begin
    state_nxt_s  = state_r;
    accept_s     = in_valid & in_ready_r;
    start_acc_s  = 1'b0;
    data_acc_s   = 1'b0;
    word_done_s  = 1'b0;
    enter_done_s = 1'b0;
    enter_err_s  = 1'b0;
    len_s        = {len_hi_r, in_data};
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_nxt_s = ST_LEN_HI;
          start_acc_s = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_LEN_HI: begin
        if (accept_s) begin
          state_nxt_s = ST_LEN_LO;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_LEN_LO: begin
        if (accept_s) begin
          if (len_s == 16'd0) begin
`ifdef LOADER_CSUM_EN
            state_nxt_s = ST_CSUM;
`else
            state_nxt_s  = ST_DONE;
            enter_done_s = 1'b1;
`endif
          end else if ({1'b0, len_s} > MAX_WORDS_C) begin
            state_nxt_s = ST_ERR;
            enter_err_s = 1'b1;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_DATA: begin
        data_acc_s = accept_s;
        // Lane 3 closes a word; the last word of the image ends the data phase.
        if (accept_s && (lane_r == 2'd3)) begin
          word_done_s = 1'b1;
          if (words_left_r == 17'd1) begin
`ifdef LOADER_CSUM_EN
            state_nxt_s = ST_CSUM;
`else
            state_nxt_s  = ST_DONE;
            enter_done_s = 1'b1;
`endif
          end else begin
            state_nxt_s = state_r;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
`ifdef LOADER_CSUM_EN
      ST_CSUM: begin
        if (accept_s) begin
          if (in_data == csum_r) begin
            state_nxt_s  = ST_DONE;
            enter_done_s = 1'b1;
          end else begin
            state_nxt_s = ST_ERR;
            enter_err_s = 1'b1;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
`endif
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // in_ready is registered from the next state so it tracks the state exactly.
  always_comb begin
    in_ready_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_LEN_HI, ST_LEN_LO, ST_DATA: in_ready_nxt_s = 1'b1;
`ifdef LOADER_CSUM_EN
      ST_CSUM:                       in_ready_nxt_s = 1'b1;
`endif
      default:                       in_ready_nxt_s = 1'b0;
    endcase
  end

  // State register and the handshake ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= in_ready_nxt_s;
    end
  end

  // Length capture, remaining-word count, and byte-lane packing buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_hi_r     <= 8'd0;
      words_left_r <= 17'd0;
      lane_r       <= 2'd0;
      buf_r        <= 24'd0;
    end else begin
      if (start_acc_s) begin
        lane_r <= 2'd0;
      end else if (data_acc_s) begin
        lane_r <= lane_r + 2'd1;
        case (lane_r)
          2'd0:    buf_r[23:16] <= in_data;
          2'd1:    buf_r[15:8]  <= in_data;
          2'd2:    buf_r[7:0]   <= in_data;
          default: buf_r        <= buf_r;  // lane 3 goes straight to the word
        endcase
      end else begin
        lane_r <= lane_r;
      end

      if ((state_r == ST_LEN_HI) && accept_s) begin
        len_hi_r <= in_data;
      end else begin
        len_hi_r <= len_hi_r;
      end

      if ((state_r == ST_LEN_LO) && accept_s) begin
        words_left_r <= {1'b0, len_s};
      end else if (word_done_s) begin
        words_left_r <= words_left_r - 17'd1;
      end else begin
        words_left_r <= words_left_r;
      end
    end
  end

`ifdef LOADER_CSUM_EN
  // Running XOR over the data bytes, restarted by each accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_r <= 8'd0;
    end else if (start_acc_s) begin
      csum_r <= 8'd0;
    end else if (data_acc_s) begin
      csum_r <= csum_update(csum_r, in_data);
    end else begin
      csum_r <= csum_r;
    end
  end
`endif

  // Memory write port. next_addr_r may wrap after the final word of a full
  // image, but no further write can follow, so imem_addr never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we_r    <= 1'b0;
      imem_addr_r  <= {ADDR_W{1'b0}};
      imem_wdata_r <= 32'd0;
      next_addr_r  <= {ADDR_W{1'b0}};
    end else begin
      imem_we_r <= word_done_s;
      if (word_done_s) begin
        imem_addr_r  <= next_addr_r;
        imem_wdata_r <= {buf_r, in_data};
        next_addr_r  <= next_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else if (start_acc_s) begin
        next_addr_r  <= {ADDR_W{1'b0}};
      end else begin
        next_addr_r  <= next_addr_r;
      end
    end
  end

  // Status flags: hold the core until DONE; done and error are exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_hold_r <= 1'b1;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else if (start_acc_s) begin
      cpu_hold_r <= 1'b1;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else if (enter_done_s) begin
      cpu_hold_r <= 1'b0;
      done_r     <= 1'b1;
      error_r    <= 1'b0;
    end else if (enter_err_s) begin
      cpu_hold_r <= 1'b1;
      done_r     <= 1'b0;
      error_r    <= 1'b1;
    end else begin
      cpu_hold_r <= cpu_hold_r;
      done_r     <= done_r;
      error_r    <= error_r;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader (ADDR_W = 8). A byte-level model of the
// load protocol predicts, for every accepted byte, the expected status flags
// and the expected memory writes (address, word, cycle). A monitor compares
// the DUT against that model on every falling edge. Directed scenarios also
// pin literal results.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int AW = 8;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    int          addr;
    logic [31:0] data;
    int          due;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  wr_t         exp_q[$];
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err  = 1'b0;
  bit          m_hold = 1'b1;
  int          m_idx  = 0;
  int          m_len  = 0;
  logic [31:0] m_word = 32'd0;
  logic [7:0]  m_csum = 8'd0;

  function automatic void model_reset();
    exp_q.delete();
    m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_hold = 1'b1;
  endfunction

  function automatic void model_start();
    if (!m_busy) begin
      m_busy = 1'b1; m_done = 1'b0; m_err = 1'b0; m_hold = 1'b1;
      m_idx = 0; m_len = 0; m_csum = 8'd0;
    end
  endfunction

  function automatic void model_finish(input bit ok);
    m_busy = 1'b0;
    m_done = ok;
    m_err  = !ok;
    m_hold = !ok;
  endfunction

  function automatic void model_data_end();
`ifndef LOADER_CSUM_EN
    model_finish(1'b1);
`endif
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int d;
    if (m_idx == 0) begin
      m_len = int'(b) << 8;
    end else if (m_idx == 1) begin
      m_len = m_len + int'(b);
      if (m_len > (1 << AW)) model_finish(1'b0);
      else if (m_len == 0) model_data_end();
    end else if (m_idx < 2 + 4 * m_len) begin
      d = m_idx - 2;
      m_word = {m_word[23:0], b};
      m_csum = m_csum ^ b;
      if (d % 4 == 3) exp_q.push_back('{d / 4, m_word, cyc});
      if (d == 4 * m_len - 1) model_data_end();
    end else begin
      model_finish(b == m_csum);
    end
    m_idx++;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      wr_t w;
      check("in_ready", in_ready, m_busy);
      check("done", done, m_done);
      check("error", error, m_err);
      check("cpu_hold", cpu_hold, m_hold);
      if (imem_we) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_we: got write addr %0h data %0h, expected none", imem_addr, imem_wdata);
        end else begin
          w = exp_q.pop_front();
          check("we_cycle", cyc, w.due);
          check("we_addr", imem_addr, w.addr);
          check("we_data", imem_wdata, w.data);
          wr_count++;
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        n_tests++; n_fail++;
        $display("FAIL missing_we: got no write, expected addr %0h data %0h", exp_q[0].addr, exp_q[0].data);
        w = exp_q.pop_front();
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_start();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got = 1'b0;
    bit rdy;
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) got = 1'b1;
    end
    in_valid = 1'b0;
    if (got) model_byte(b);
    else begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: got in_ready low for 50 cycles, expected byte %0h accepted", b);
    end
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // Sends a stream; in the checksum build the correct checksum is appended.
  task automatic run_image(input byte_q_t q, input int gap, input bit add_csum);
    logic [7:0] x = 8'h00;
    for (int i = 2; i < q.size(); i++) x = x ^ q[i];
`ifdef LOADER_CSUM_EN
    if (add_csum) q.push_back(x);
`endif
    foreach (q[i]) send_byte(q[i], gap);
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected end within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t img2;
    byte_q_t q;
    img2 = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold", cpu_hold, 1'b1);
    check("rst_ready", in_ready, 1'b0);
    check("rst_addr", imem_addr, 8'h00);
    check("rst_done", done, 1'b0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-word load at one byte per cycle.
    wr_count = 0;
    do_start();
    check("start_ready", in_ready, 1'b1);
    run_image(img2, 0, 1'b1);
    check("t1_writes", wr_count, 2);
    check("t1_addr", imem_addr, 8'h01);
    check("t1_wdata", imem_wdata, 32'h8C090004);
    check("t1_done", done, 1'b1);
    check("t1_hold", cpu_hold, 1'b0);

    // Same image, in_valid toggling every cycle.
    wr_count = 0;
    do_start();
    run_image(img2, 1, 1'b1);
    check("t2_writes", wr_count, 2);
    check("t2_wdata", imem_wdata, 32'h8C090004);
    check("t2_done", done, 1'b1);

    // Oversize length: 257 words.
    wr_count = 0;
    do_start();
    q = '{8'h01, 8'h01};
    run_image(q, 0, 1'b0);
    check("t3_error", error, 1'b1);
    check("t3_done", done, 1'b0);
    check("t3_hold", cpu_hold, 1'b1);
    check("t3_ready", in_ready, 1'b0);
    check("t3_writes", wr_count, 0);

    // Zero length.
    wr_count = 0;
    do_start();
    q = '{8'h00, 8'h00};
    run_image(q, 0, 1'b1);
    check("t4_done", done, 1'b1);
    check("t4_error", error, 1'b0);
    check("t4_writes", wr_count, 0);

    // start pulsed during DATA is ignored.
    wr_count = 0;
    do_start();
    for (int i = 0; i < 6; i++) send_byte(img2[i], 0);
    do_start();
    check("t5_addr_hold", imem_addr, 8'h00);
    check("t5_ready", in_ready, 1'b1);
    q = '{};
    for (int i = 6; i < 10; i++) q.push_back(img2[i]);
    foreach (q[i]) send_byte(q[i], 0);
`ifdef LOADER_CSUM_EN
    send_byte(8'h20 ^ 8'h08 ^ 8'h00 ^ 8'h05 ^ 8'h8C ^ 8'h09 ^ 8'h00 ^ 8'h04, 0);
`endif
    settle();
    check("t5_writes", wr_count, 2);
    check("t5_addr", imem_addr, 8'h01);
    check("t5_done", done, 1'b1);

    // Reset after six data bytes, then a fresh load.
    do_start();
    q = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    foreach (q[i]) send_byte(q[i], 0);
    rst_n = 1'b0;
    #1;
    check("t6_ready", in_ready, 1'b0);
    check("t6_we", imem_we, 1'b0);
    check("t6_addr", imem_addr, 8'h00);
    check("t6_wdata", imem_wdata, 32'h0);
    check("t6_hold", cpu_hold, 1'b1);
    check("t6_done", done, 1'b0);
    check("t6_error", error, 1'b0);
    model_reset();
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    wr_count = 0;
    do_start();
    run_image(img2, 0, 1'b1);
    check("t6_writes", wr_count, 2);
    check("t6_addr_end", imem_addr, 8'h01);
    check("t6_done_end", done, 1'b1);

    // Full 256-word image.
    wr_count = 0;
    do_start();
    q = '{8'h01, 8'h00};
    for (int i = 0; i < 1024; i++) q.push_back(8'((i * 7 + 3) & 255));
    run_image(q, 0, 1'b1);
    check("t7_writes", wr_count, 256);
    check("t7_addr", imem_addr, 8'hFF);
    check("t7_wdata", imem_wdata, {8'((1020*7+3)&255), 8'((1021*7+3)&255), 8'((1022*7+3)&255), 8'((1023*7+3)&255)});
    check("t7_done", done, 1'b1);

`ifdef LOADER_CSUM_EN
    // Checksum match and mismatch.
    do_start();
    q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    run_image(q, 0, 1'b0);
    check("t8_done", done, 1'b1);
    check("t8_error", error, 1'b0);
    do_start();
    q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    run_image(q, 0, 1'b0);
    check("t9_error", error, 1'b1);
    check("t9_done", done, 1'b0);
    check("t9_hold", cpu_hold, 1'b1);
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
